// File: rtl/result_checker_pkg.sv
// rtl/result_checker_pkg.sv - shared state encoding and default widths for the result checker
package result_checker_pkg;

    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_CYCLE_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        RUN,
        WAIT_DONE,
        SCAN,
        DRAIN,
        FINISH
    } state_t;

endpackage

// File: rtl/result_checker_scan.sv
// rtl/result_checker_scan.sv - address walker and registered compare stage
//
// Purpose: on a go pulse, issues base_addr + i (i = 0..num_results-1, wrapping)
// to both SRAMs, one address per cycle, and compares the read words one cycle
// after each address in a registered stage.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   go                               one-cycle pulse launching a scan (ignored if num_results = 0)
//   base_addr, num_results           first address and word count
//   result_read_data, golden_read_data  SRAM read data, valid one cycle after address
//   result_read_address, golden_read_address  issued addresses (identical)
//   match_inc                        one-cycle pulse per equal pair
//   scan_done                        pulses together with the last compare result
//   miss, miss_addr, miss_result, miss_golden  per-compare mismatch report
//                                    (only with RESULT_CHECKER_MISMATCH_LOG_EN)
module result_checker_scan
    import result_checker_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_results,
    input  logic [DATA_WIDTH-1:0] result_read_data,
    input  logic [DATA_WIDTH-1:0] golden_read_data,
    output logic [ADDR_WIDTH-1:0] result_read_address,
    output logic [ADDR_WIDTH-1:0] golden_read_address,
    output logic                  match_inc,
    output logic                  scan_done
`ifdef RESULT_CHECKER_MISMATCH_LOG_EN
    ,
    output logic                  miss,
    output logic [ADDR_WIDTH-1:0] miss_addr,
    output logic [DATA_WIDTH-1:0] miss_result,
    output logic [DATA_WIDTH-1:0] miss_golden
`endif
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   rem_q;      // addresses still to issue after the current one
    logic                  issue_q;    // addr_q is a live address this cycle
    logic                  valid_q;    // read data on the buses belongs to a live address
    logic                  vlast_q;    // ... and it is the last one of the scan
    logic                  match_q;
    logic                  done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            rem_q   <= '0;
            issue_q <= 1'b0;
            valid_q <= 1'b0;
            vlast_q <= 1'b0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= issue_q;
            vlast_q <= issue_q && (rem_q == '0);
            match_q <= valid_q && (result_read_data == golden_read_data);
            done_q  <= vlast_q;
            if (go && (num_results != '0)) begin
                addr_q  <= base_addr;
                rem_q   <= num_results - REM_ONE;
                issue_q <= 1'b1;
            end else if (issue_q) begin
                if (rem_q == '0) begin
                    issue_q <= 1'b0;
                end else begin
                    addr_q <= addr_q + ADDR_ONE;   // natural wrap at 2^ADDR_WIDTH
                    rem_q  <= rem_q - REM_ONE;
                end
            end
        end
    end

    assign result_read_address = addr_q;
    assign golden_read_address = addr_q;
    assign match_inc           = match_q;
    assign scan_done           = done_q;

`ifdef RESULT_CHECKER_MISMATCH_LOG_EN
    // Address whose data is on the read buses this cycle.
    logic [ADDR_WIDTH-1:0] addr_d1_q;
    logic                  miss_q;
    logic [ADDR_WIDTH-1:0] miss_addr_q;
    logic [DATA_WIDTH-1:0] miss_res_q;
    logic [DATA_WIDTH-1:0] miss_gold_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_d1_q   <= '0;
            miss_q      <= 1'b0;
            miss_addr_q <= '0;
            miss_res_q  <= '0;
            miss_gold_q <= '0;
        end else begin
            addr_d1_q   <= addr_q;
            miss_q      <= valid_q && (result_read_data != golden_read_data);
            miss_addr_q <= addr_d1_q;
            miss_res_q  <= result_read_data;
            miss_gold_q <= golden_read_data;
        end
    end

    assign miss        = miss_q;
    assign miss_addr   = miss_addr_q;
    assign miss_result = miss_res_q;
    assign miss_golden = miss_gold_q;
`endif

endmodule

// File: rtl/result_checker.sv
// rtl/result_checker.sv - runs a DUT round, times it, and compares its results against golden data
//
// Purpose: on start, waits for the DUT to be idle, launches it with dut_run,
// counts cycles until it finishes (optionally bounded by timeout_cycles), then
// walks num_results words of result and golden SRAM and reports the match count.
// Optional feature macro: RESULT_CHECKER_MISMATCH_LOG_EN adds a first-mismatch log.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   start                          one-cycle pulse arming a round (IDLE only)
//   base_addr, num_results, timeout_cycles  round parameters, captured at start
//   dut_run / dut_busy             DUT handshake
//   result_read_address/_data      result SRAM port (data one cycle after address)
//   golden_read_address/_data      golden SRAM port (data one cycle after address)
//   checker_busy, done, pass, timed_out, correct_count, compute_cycles  status
//   mm_valid, mm_addr, mm_result, mm_golden  first mismatch of the round (macro only)
module result_checker
    import result_checker_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int CYCLE_WIDTH = DEF_CYCLE_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [ADDR_WIDTH:0]    num_results,
    input  logic [CYCLE_WIDTH-1:0] timeout_cycles,
    output logic                   dut_run,
    input  logic                   dut_busy,
    output logic [ADDR_WIDTH-1:0]  result_read_address,
    input  logic [DATA_WIDTH-1:0]  result_read_data,
    output logic [ADDR_WIDTH-1:0]  golden_read_address,
    input  logic [DATA_WIDTH-1:0]  golden_read_data,
    output logic                   checker_busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timed_out,
    output logic [ADDR_WIDTH:0]    correct_count,
    output logic [CYCLE_WIDTH-1:0] compute_cycles
`ifdef RESULT_CHECKER_MISMATCH_LOG_EN
    ,
    output logic                   mm_valid,
    output logic [ADDR_WIDTH-1:0]  mm_addr,
    output logic [DATA_WIDTH-1:0]  mm_result,
    output logic [DATA_WIDTH-1:0]  mm_golden
`endif
);

    localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
    localparam logic [CYCLE_WIDTH-1:0] CYC_ONE = 1;

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [ADDR_WIDTH:0]    num_q;
    logic [CYCLE_WIDTH-1:0] tmo_q;
    logic [CYCLE_WIDTH-1:0] cnt_q;
    logic                   dut_run_q;
    logic                   go_q;
    logic                   done_q;
    logic                   pass_q;
    logic                   timed_out_q;
    logic [ADDR_WIDTH:0]    count_q;
    logic [CYCLE_WIDTH-1:0] cycles_q;

    logic                   match_inc;
    logic                   scan_done;
    logic [ADDR_WIDTH:0]    count_next;
    logic                   tmo_hit;

    assign count_next = match_inc ? (count_q + CNT_ONE) : count_q;
    assign tmo_hit    = (tmo_q != '0) && (cnt_q >= tmo_q);

`ifdef RESULT_CHECKER_MISMATCH_LOG_EN
    logic                  miss;
    logic [ADDR_WIDTH-1:0] miss_addr;
    logic [DATA_WIDTH-1:0] miss_result;
    logic [DATA_WIDTH-1:0] miss_golden;
    logic                  mm_valid_q;
    logic [ADDR_WIDTH-1:0] mm_addr_q;
    logic [DATA_WIDTH-1:0] mm_result_q;
    logic [DATA_WIDTH-1:0] mm_golden_q;
`endif

    result_checker_scan #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_scan (
        .clk                 (clk),
        .reset               (reset),
        .go                  (go_q),
        .base_addr           (base_q),
        .num_results         (num_q),
        .result_read_data    (result_read_data),
        .golden_read_data    (golden_read_data),
        .result_read_address (result_read_address),
        .golden_read_address (golden_read_address),
        .match_inc           (match_inc),
        .scan_done           (scan_done)
`ifdef RESULT_CHECKER_MISMATCH_LOG_EN
        ,
        .miss                (miss),
        .miss_addr           (miss_addr),
        .miss_result         (miss_result),
        .miss_golden         (miss_golden)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            num_q       <= '0;
            tmo_q       <= '0;
            cnt_q       <= '0;
            dut_run_q   <= 1'b0;
            go_q        <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b0;
            count_q     <= '0;
            cycles_q    <= '0;
`ifdef RESULT_CHECKER_MISMATCH_LOG_EN
            mm_valid_q  <= 1'b0;
            mm_addr_q   <= '0;
            mm_result_q <= '0;
            mm_golden_q <= '0;
`endif
        end else begin
            go_q    <= 1'b0;
            done_q  <= 1'b0;
            count_q <= count_next;
`ifdef RESULT_CHECKER_MISMATCH_LOG_EN
            if (miss && !mm_valid_q) begin
                mm_valid_q  <= 1'b1;
                mm_addr_q   <= miss_addr;
                mm_result_q <= miss_result;
                mm_golden_q <= miss_golden;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q      <= base_addr;
                        num_q       <= num_results;
                        tmo_q       <= timeout_cycles;
                        cnt_q       <= '0;
                        count_q     <= '0;
                        timed_out_q <= 1'b0;
                        pass_q      <= 1'b0;
`ifdef RESULT_CHECKER_MISMATCH_LOG_EN
                        mm_valid_q  <= 1'b0;
                        mm_addr_q   <= '0;
                        mm_result_q <= '0;
                        mm_golden_q <= '0;
`endif
                        state_q     <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (!dut_busy) begin
                        dut_run_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= RUN;
                    end else if (tmo_hit) begin
                        timed_out_q <= 1'b1;
                        dut_run_q   <= 1'b0;
                        pass_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= FINISH;
                    end else begin
                        cnt_q <= cnt_q + CYC_ONE;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CYC_ONE;
                    if (dut_busy) begin
                        dut_run_q <= 1'b0;
                        state_q   <= WAIT_DONE;
                    end else if (tmo_hit) begin
                        timed_out_q <= 1'b1;
                        dut_run_q   <= 1'b0;
                        pass_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= FINISH;
                    end
                end
                WAIT_DONE: begin
                    if (!dut_busy) begin
                        cycles_q <= cnt_q;
                        go_q     <= (num_q != '0);
                        state_q  <= SCAN;
                    end else if (tmo_hit) begin
                        timed_out_q <= 1'b1;
                        pass_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= FINISH;
                    end else begin
                        cnt_q <= cnt_q + CYC_ONE;
                    end
                end
                SCAN: begin
                    // go_q is high this cycle; the walker takes over from here.
                    if (num_q == '0) begin
                        pass_q  <= !timed_out_q;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // scan_done coincides with the last match_inc, so use the updated count.
                    if (scan_done) begin
                        pass_q  <= (count_next == num_q) && !timed_out_q;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dut_run        = dut_run_q;
    assign checker_busy   = (state_q != IDLE);
    assign done           = done_q;
    assign pass           = pass_q;
    assign timed_out      = timed_out_q;
    assign correct_count  = count_q;
    assign compute_cycles = cycles_q;

`ifdef RESULT_CHECKER_MISMATCH_LOG_EN
    assign mm_valid  = mm_valid_q;
    assign mm_addr   = mm_addr_q;
    assign mm_result = mm_result_q;
    assign mm_golden = mm_golden_q;
`endif

endmodule

// File: tb/tb_result_checker.sv
// tb/tb_result_checker.sv - randomized self-checking bench for result_checker
module tb_result_checker;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int CW = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_results;
    logic [CW-1:0] timeout_cycles;
    logic          dut_run;
    logic          dut_busy;
    logic [AW-1:0] result_read_address;
    logic [DW-1:0] result_read_data;
    logic [AW-1:0] golden_read_address;
    logic [DW-1:0] golden_read_data;
    logic          checker_busy;
    logic          done;
    logic          pass;
    logic          timed_out;
    logic [AW:0]   correct_count;
    logic [CW-1:0] compute_cycles;
`ifdef RESULT_CHECKER_MISMATCH_LOG_EN
    logic          mm_valid;
    logic [AW-1:0] mm_addr;
    logic [DW-1:0] mm_result;
    logic [DW-1:0] mm_golden;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    result_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CYCLE_WIDTH(CW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .base_addr           (base_addr),
        .num_results         (num_results),
        .timeout_cycles      (timeout_cycles),
        .dut_run             (dut_run),
        .dut_busy            (dut_busy),
        .result_read_address (result_read_address),
        .result_read_data    (result_read_data),
        .golden_read_address (golden_read_address),
        .golden_read_data    (golden_read_data),
        .checker_busy        (checker_busy),
        .done                (done),
        .pass                (pass),
        .timed_out           (timed_out),
        .correct_count       (correct_count),
        .compute_cycles      (compute_cycles)
`ifdef RESULT_CHECKER_MISMATCH_LOG_EN
        ,
        .mm_valid            (mm_valid),
        .mm_addr             (mm_addr),
        .mm_result           (mm_result),
        .mm_golden           (mm_golden)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous SRAMs: data appears one cycle after the address.
    logic [DW-1:0] res_mem  [DEPTH];
    logic [DW-1:0] gold_mem [DEPTH];
    always @(posedge clk) begin
        result_read_data <= res_mem[result_read_address];
        golden_read_data <= gold_mem[golden_read_address];
    end

    // DUT model: sees dut_run on an edge, then holds busy for hold_cycles cycles.
    int hold_cycles = 1;
    int busy_left;
    always @(posedge clk or posedge reset) begin
        if (reset)              busy_left <= 0;
        else if (busy_left > 0) busy_left <= busy_left - 1;
        else if (dut_run)       busy_left <= hold_cycles;
    end
    assign dut_busy = (busy_left != 0);

    // Address log and done-pulse counter.
    logic [AW-1:0] addr_log[$];
    int            done_cnt = 0;
    int            addr_diff = 0;
    always @(negedge clk) begin
        addr_log.push_back(result_read_address);
        if (result_read_address !== golden_read_address) addr_diff++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: count equal words over the wrapped window, find the first difference.
    function automatic int ref_count(input int b, input int n);
        int c = 0;
        for (int i = 0; i < n; i++)
            if (res_mem[(b + i) % DEPTH] == gold_mem[(b + i) % DEPTH]) c++;
        return c;
    endfunction

    function automatic int ref_first_miss(input int b, input int n);
        for (int i = 0; i < n; i++)
            if (res_mem[(b + i) % DEPTH] != gold_mem[(b + i) % DEPTH]) return (b + i) % DEPTH;
        return -1;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < DEPTH; i++) begin
            res_mem[i]  = DW'($urandom);
            gold_mem[i] = res_mem[i];
        end
    endtask

    task automatic corrupt(input int a);
        gold_mem[a % DEPTH] = gold_mem[a % DEPTH] ^ DW'(1 << $urandom_range(0, DW - 1));
    endtask

    task automatic pulse_start(input int b, input int n, input int t, input int h);
        base_addr      = AW'(b);
        num_results    = (AW + 1)'(n);
        timeout_cycles = CW'(t);
        hold_cycles    = h;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    // Full round with the reference expectations.
    task automatic round(input string tag, input int b, input int n, input int h);
        int exp_cnt = ref_count(b, n);
`ifdef RESULT_CHECKER_MISMATCH_LOG_EN
        int fm = ref_first_miss(b, n);
`endif
        pulse_start(b, n, 0, h);
        wait_done(tag, h + n + 200);
        check({tag, "_count"}, 64'(correct_count), 64'(exp_cnt));
        check({tag, "_pass"}, 64'(pass), 64'(exp_cnt == n));
        check({tag, "_timed_out"}, 64'(timed_out), 64'd0);
        check({tag, "_cycles"}, 64'(compute_cycles), 64'(h + 1));
`ifdef RESULT_CHECKER_MISMATCH_LOG_EN
        check({tag, "_mm_valid"}, 64'(mm_valid), 64'(fm >= 0));
        if (fm >= 0) check({tag, "_mm_addr"}, 64'(mm_addr), 64'(fm));
`endif
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(checker_busy), 64'd0);
    endtask

    initial begin
        int k;
        int d0;
        logic [AW-1:0] pre;
        bit found;

        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        num_results = '0;
        timeout_cycles = '0;
        fill_mem();
        repeat (3) @(negedge clk);
        check("rst_run", 64'(dut_run), 64'd0);
        check("rst_busy", 64'(checker_busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_count", 64'(correct_count), 64'd0);
        check("rst_cycles", 64'(compute_cycles), 64'd0);
        check("rst_raddr", 64'(result_read_address), 64'd0);
        check("rst_gaddr", 64'(golden_read_address), 64'd0);
        reset = 1'b0;

        // 72 matching words, DUT busy for 40 cycles.
        round("basic72", 0, 72, 40);

        // Golden words 5 and 17 corrupted.
        corrupt(5);
        corrupt(17);
        round("corrupt", 0, 32, 12);
        fill_mem();

        // Wrap at the top of the address space.
        addr_log.delete();
        round("wrap", 12'hFFE, 4, 3);
        found = 0;
        k = 0;
        for (int i = 1; i < addr_log.size() && !found; i++)
            if (addr_log[i] == 12'hFFE && addr_log[i-1] != 12'hFFE) begin
                found = 1;
                k = i;
            end
        check("wrap_found", 64'(found), 64'd1);
        if (found && k + 3 < addr_log.size()) begin
            check("wrap_a1", 64'(addr_log[k+1]), 64'h000000000000FFF);
            check("wrap_a2", 64'(addr_log[k+2]), 64'h0);
            check("wrap_a3", 64'(addr_log[k+3]), 64'h1);
        end

        // Randomized rounds.
        for (int r = 0; r < 8; r++) begin
            int b = $urandom_range(0, DEPTH - 1);
            int n = $urandom_range(0, 150);
            int nc = (n > 0) ? $urandom_range(0, 3) : 0;
            fill_mem();
            for (int j = 0; j < nc; j++) corrupt(b + $urandom_range(0, n - 1));
            round($sformatf("rnd%0d", r), b, n, $urandom_range(1, 30));
        end

        // DUT never finishes: timeout.
        pre = result_read_address;
        d0 = int'(compute_cycles);
        addr_log.delete();
        pulse_start((int'(pre) + 40) % DEPTH, 4, 100, 1000000);
        wait_done("tmo", 400);
        check("tmo_flag", 64'(timed_out), 64'd1);
        check("tmo_run", 64'(dut_run), 64'd0);
        check("tmo_pass", 64'(pass), 64'd0);
        check("tmo_cycles_kept", 64'(compute_cycles), 64'(d0));
        k = 0;
        foreach (addr_log[i]) if (addr_log[i] != pre) k++;
        check("tmo_no_scan", 64'(k), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-scan.
        fill_mem();
        pulse_start(12'h200, 200, 0, 5);
        found = 0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (result_read_address == 12'h20A) found = 1;
        end
        check("rscan_reached", 64'(found), 64'd1);
        d0 = done_cnt;
        #2 reset = 1'b1;
        #1;
        check("rscan_run", 64'(dut_run), 64'd0);
        check("rscan_busy", 64'(checker_busy), 64'd0);
        check("rscan_count", 64'(correct_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rscan_no_done", 64'(done_cnt), 64'(d0));
        corrupt(12'h210);
        round("rscan_fresh", 12'h200, 30, 7);

        // start during RUN is ignored; zero-length round.
        pulse_start(12'h050, 0, 0, 20);
        found = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (dut_run === 1'b1) found = 1;
            else @(negedge clk);
        end
        check("restart_run_seen", 64'(found), 64'd1);
        num_results = 5;
        base_addr = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("restart", 200);
        check("restart_pass", 64'(pass), 64'd1);
        check("restart_count", 64'(correct_count), 64'd0);
        check("restart_cycles", 64'(compute_cycles), 64'd21);
        repeat (3) @(negedge clk);
        check("restart_idle", 64'(checker_busy), 64'd0);

        check("addr_equal", 64'(addr_diff), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
